// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - round-robin AHB bus arbiter with burst and lock protection
//
// Shares one AHB slave path among NUM_MASTERS masters. Grants rotate from the
// master after the last one newly granted. The grant is held while the owner
// keeps HLOCK asserted or while two or more addresses of a fixed burst remain.
// With no requests the bus is parked on DEFAULT_MASTER. All state advances
// only on edges that accept a transfer (HREADY=1).
//
// Ports:
//   HCLK       bus clock, rising edge
//   HRESET     synchronous active-high reset
//   HBUSREQ    per-master bus request
//   HLOCK      per-master locked-transfer request
//   HTRANS     muxed transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HBURST     muxed burst type
//   HREADY     muxed slave ready; a transfer is accepted when high
//   HGRANT     one-hot grant, registered
//   HMASTER    index of the address-phase owner, registered
//   HMASTLOCK  address-phase owner is in a locked sequence, registered
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [NUM_MASTERS-1:0]         HBUSREQ,
  input  logic [NUM_MASTERS-1:0]         HLOCK,
  input  logic [1:0]                     HTRANS,
  input  logic [2:0]                     HBURST,
  input  logic                           HREADY,
  output logic [NUM_MASTERS-1:0]         HGRANT,
  output logic [$clog2(NUM_MASTERS)-1:0] HMASTER,
  output logic                           HMASTLOCK
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [IW-1:0]          DEF_IDX   = IW'(DEFAULT_MASTER);

  logic [IW-1:0]          rr_last;
  logic [4:0]             beats_left;

  logic [4:0]             burst_len;
  logic [4:0]             beats_next;
  logic [IW-1:0]          grant_idx;
  logic                   hold;
  logic                   arb_found;
  logic [IW-1:0]          arb_idx;
  logic [NUM_MASTERS-1:0] arb_grant;

  function automatic logic [IW-1:0] wrap_idx(input int v);
    return IW'(v % NUM_MASTERS);
  endfunction

  // SINGLE and INCR are unprotected: length 1 means no hold.
  always_comb begin
    case (HBURST)
      3'b010, 3'b011: burst_len = 5'd4;
      3'b100, 3'b101: burst_len = 5'd8;
      3'b110, 3'b111: burst_len = 5'd16;
      default:        burst_len = 5'd1;
    endcase
  end

  // Remaining address phases after the one accepted at this edge.
  always_comb begin
    case (HTRANS)
      2'b10:   beats_next = burst_len - 5'd1;
      2'b11:   beats_next = (beats_left != 5'd0) ? beats_left - 5'd1 : 5'd0;
      2'b01:   beats_next = beats_left;
      default: beats_next = 5'd0;   // IDLE ends any burst early
    endcase
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (HGRANT[i]) grant_idx = IW'(i);
    end
  end

  // Holding while beats_next >= 2 lets the owner issue its final address
  // before the grant moves on.
  assign hold = HLOCK[grant_idx] || (beats_next >= 5'd2);

  // Rotating search starting just after the last master newly granted.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = rr_last;
    arb_grant = DEF_GRANT;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      if (!arb_found && HBUSREQ[wrap_idx(int'(rr_last) + k)]) begin
        arb_found = 1'b1;
        arb_idx   = wrap_idx(int'(rr_last) + k);
      end
    end
    if (arb_found) begin
      arb_grant          = '0;
      arb_grant[arb_idx] = 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HGRANT     <= DEF_GRANT;
      HMASTER    <= DEF_IDX;
      HMASTLOCK  <= 1'b0;
      rr_last    <= DEF_IDX;
      beats_left <= 5'd0;
    end else if (HREADY) begin
      HMASTER    <= grant_idx;
      HMASTLOCK  <= HLOCK[grant_idx];
      beats_left <= beats_next;
      if (!hold) begin
        HGRANT <= arb_grant;
        if (arb_found) rr_last <= arb_idx;
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - self-checking bench for ahb_arbiter
module tb_ahb_arbiter;

  localparam int N   = 4;
  localparam int DEF = 0;

  logic         HCLK = 1'b0;
  logic         HRESET;
  logic [N-1:0] HBUSREQ;
  logic [N-1:0] HLOCK;
  logic [1:0]   HTRANS;
  logic [2:0]   HBURST;
  logic         HREADY;
  logic [N-1:0] HGRANT;
  logic [1:0]   HMASTER;
  logic         HMASTLOCK;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_grant, m_master, m_lock, m_rr, m_beats;

  ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY),
    .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model of one clock edge, applied to the inputs seen at that edge.
  task automatic model_edge();
    int len, bn, winner, c;
    bit hold;
    if (HRESET) begin
      m_grant = DEF; m_master = DEF; m_lock = 0; m_rr = DEF; m_beats = 0;
      return;
    end
    if (!HREADY) return;
    len = (HBURST < 3'd2) ? 1 : (4 << ((int'(HBURST) - 2) / 2));
    if (HTRANS == 2'b10)      bn = len - 1;
    else if (HTRANS == 2'b11) bn = (m_beats > 0) ? m_beats - 1 : 0;
    else if (HTRANS == 2'b01) bn = m_beats;
    else                      bn = 0;
    hold = HLOCK[m_grant] || (bn >= 2);
    m_master = m_grant;
    m_lock   = HLOCK[m_grant];
    m_beats  = bn;
    if (!hold) begin
      winner = -1;
      for (int k = 1; k <= N; k++) begin
        c = (m_rr + k) % N;
        if (winner < 0 && HBUSREQ[c]) winner = c;
      end
      if (winner >= 0) begin
        m_grant = winner;
        m_rr    = winner;
      end else begin
        m_grant = DEF;
      end
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    model_edge();
    @(negedge HCLK);
    chk("model_grant",  32'(HGRANT),         32'(1 << m_grant));
    chk("model_master", 32'(HMASTER),        32'(m_master));
    chk("model_lock",   32'(HMASTLOCK),      32'(m_lock));
    chk("model_beats",  32'(dut.beats_left), 32'(m_beats));
  endtask

  initial begin
    int exp_grant[5];
    int exp_master[5];
    exp_grant  = '{2, 4, 8, 1, 2};
    exp_master = '{0, 1, 2, 3, 0};
    m_grant = DEF; m_master = DEF; m_lock = 0; m_rr = DEF; m_beats = 0;

    HRESET = 1'b1; HBUSREQ = '0; HLOCK = '0; HTRANS = 2'b00; HBURST = 3'b000; HREADY = 1'b1;

    // Reset and park
    step(); step();
    HRESET = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("park_grant", 32'(HGRANT), 32'h1);
      chk("park_master", 32'(HMASTER), 32'h0);
      chk("park_lock", 32'(HMASTLOCK), 32'h0);
    end

    // Round-robin with all masters requesting single transfers
    HBUSREQ = 4'b1111; HTRANS = 2'b10; HBURST = 3'b000;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_grant", 32'(HGRANT), 32'(exp_grant[i]));
      chk("rr_master", 32'(HMASTER), 32'(exp_master[i]));
    end

    // INCR4 protection: master 1 owns, master 2 requests
    HBUSREQ = 4'b0100; HTRANS = 2'b10; HBURST = 3'b011;
    step(); chk("incr4_nonseq_grant", 32'(HGRANT), 32'h2);
    HTRANS = 2'b11;
    step(); chk("incr4_seq1_grant", 32'(HGRANT), 32'h2);
    step(); chk("incr4_seq2_grant", 32'(HGRANT), 32'h4);
    step(); chk("incr4_seq3_master", 32'(HMASTER), 32'h2);
    HTRANS = 2'b00;
    step();

    // Wait states on beat 3 of an INCR4
    HBUSREQ = 4'b0010;
    step(); chk("wait_setup_grant", 32'(HGRANT), 32'h2);
    HBUSREQ = 4'b0110; HTRANS = 2'b10; HBURST = 3'b011;
    step();
    HTRANS = 2'b11;
    step();
    HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_grant", 32'(HGRANT), 32'h2);
      chk("wait_master", 32'(HMASTER), 32'h1);
      chk("wait_beats", 32'(dut.beats_left), 32'h2);
    end
    HREADY = 1'b1;
    step(); chk("wait_handover_grant", 32'(HGRANT), 32'h4);
    step(); chk("wait_handover_master", 32'(HMASTER), 32'h2);

    // Lock: master 3 holds the bus for 6 singles
    HTRANS = 2'b10; HBURST = 3'b000; HBUSREQ = 4'b1000; HLOCK = 4'b1000;
    step(); chk("lock_setup_grant", 32'(HGRANT), 32'h8);
    HBUSREQ = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("lock_grant", 32'(HGRANT), 32'h8);
      chk("lock_master", 32'(HMASTER), 32'h3);
      chk("lock_mastlock", 32'(HMASTLOCK), 32'h1);
    end
    HLOCK = 4'b0000;
    step();
    chk("lock_release_grant", 32'(HGRANT), 32'h1);
    chk("lock_release_mastlock", 32'(HMASTLOCK), 32'h0);

    // Early termination of an INCR8 by master 0
    HBUSREQ = 4'b0011; HTRANS = 2'b10; HBURST = 3'b101;
    step(); chk("early_nonseq_beats", 32'(dut.beats_left), 32'h7);
    HTRANS = 2'b11;
    step(); chk("early_seq_grant", 32'(HGRANT), 32'h1);
    HTRANS = 2'b00;
    step();
    chk("early_idle_beats", 32'(dut.beats_left), 32'h0);
    chk("early_idle_grant", 32'(HGRANT), 32'h2);

    // Randomized traffic against the model, including stalls and resets
    for (int i = 0; i < 600; i++) begin
      HRESET  = ($urandom % 80) == 0;
      HREADY  = ($urandom % 5) != 0;
      HBUSREQ = N'($urandom);
      HLOCK   = (($urandom % 4) == 0) ? (N'($urandom) & HBUSREQ) : '0;
      HTRANS  = 2'($urandom);
      HBURST  = 3'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
